jk_bank_sequencer: RTL and testbench

- Command-driven controller for an external bank of WIDTH negedge-triggered JK flip-flops with active-high async Preset/Clear.
- Sequences per-bit J/K/Preset/Clear to implement clear, preset, parallel load, count up/down, shift-left and hold operations.
- Keeps a shadow copy of the bank state so next-state J/K can be computed without combinational feedback.
- Sits between a command source (valid/ready) and the flip-flop bank.

---
 rtl/jk_bank_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// jk_bank_sequencer
// Command-driven controller for an external bank of WIDTH negedge-triggered JK
// flip-flops with active-high async Preset/Clear. It sequences per-bit J/K and
// Preset/Clear to clear, preset, load, count up/down, shift left or hold the
// bank. A shadow copy of the bank state feeds the next-state J/K computation,
// so there is no combinational path through the bank.
//
// Optional feature (macro JK_SEQ_CHECK_EN): one posedge after every shadow
// update the bank Q (q_fb) is compared with q_shadow, and any mismatch sets the
// sticky err flag (cleared only by rst_n). Without the macro the err port is
// absent and q_fb is unused.
//
// Ports:
//   clk, rst_n          clock (controller on posedge), async active-low reset
//   cmd_valid/cmd_ready command handshake, accepted on posedge when both high
//   cmd_op              0 NOP,1 CLEAR,2 PRESET,3 LOAD,4 UP,5 DOWN,6 SHL,7 HOLD
//   cmd_data            LOAD value; bit 0 is the SHL serial-in
//   cmd_len             step count for UP/DOWN/SHL/HOLD
//   q_fb                bank Q outputs (only used by the optional check)
//   jk_j, jk_k          per-bit J/K, change on posedge, sampled by bank on negedge
//   jk_preset, jk_clear per-bit async Preset/Clear (jk_clear forced high in reset)
//   q_shadow            controller's model of the bank state
//   busy, done          command in progress / one-cycle completion pulse
//   err                 sticky mismatch flag (JK_SEQ_CHECK_EN only)
// -----------------------------------------------------------------------------
module jk_bank_sequencer #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned LEN_W     = 8,
   parameter int unsigned PULSE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic [WIDTH-1:0] jk_preset,
   output logic [WIDTH-1:0] jk_clear,
   output logic [WIDTH-1:0] q_shadow,
   output logic             busy,
   output logic             done
`ifdef JK_SEQ_CHECK_EN
   ,
   output logic             err
`endif
);

   localparam int unsigned PC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_PRESET = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_UP     = 3'd4;
   localparam logic [2:0] OP_DOWN   = 3'd5;
   localparam logic [2:0] OP_SHL    = 3'd6;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PULSE   = 3'd1,
      RECOVER = 3'd2,
      STEP    = 3'd3,
      FIN     = 3'd4
   } state_e;

   // J/K for one step of op, given the current bank state s and command data d
   function automatic logic [2*WIDTH-1:0] jk_calc(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] j;
      logic [WIDTH-1:0] k;
      logic             run;
      j   = '0;
      k   = '0;
      run = 1'b1;
      case (op)
         OP_LOAD: begin
            j = d;
            k = ~d;
         end
         OP_UP: begin
            for (int i = 0; i < int'(WIDTH); i++) begin
               j[i] = run;
               run  = run & s[i];
            end
            k = j;
         end
         OP_DOWN: begin
            for (int i = 0; i < int'(WIDTH); i++) begin
               j[i] = run;
               run  = run & ~s[i];
            end
            k = j;
         end
         OP_SHL: begin
            j[0] = d[0];
            k[0] = ~d[0];
            for (int i = 1; i < int'(WIDTH); i++) begin
               j[i] = s[i-1];
               k[i] = ~s[i-1];
            end
         end
         default: ;
      endcase
      return {j, k};
   endfunction

   // JK flip-flop characteristic: Q+ = J&~Q | ~K&Q
   function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
      return (j & ~s) | (~k & s);
   endfunction

   state_e           state, state_n;
   logic [2:0]       op_q, op_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic [LEN_W-1:0] cnt_q, cnt_n;
   logic [PC_W-1:0]  pcnt_q, pcnt_n;
   logic [WIDTH-1:0] shadow_n;
   logic [WIDTH-1:0] j_n, k_n, pre_n, clr_n, clear_q;
   logic             busy_n, done_n, ready_n, upd_n;

   // Bank is held in clear for the whole reset, tracking the shadow reset
   assign jk_clear = rst_n ? clear_q : '1;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_NOP;
         data_q    <= '0;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         q_shadow  <= '0;
         jk_j      <= '0;
         jk_k      <= '0;
         jk_preset <= '0;
         clear_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_n;
         op_q      <= op_n;
         data_q    <= data_n;
         cnt_q     <= cnt_n;
         pcnt_q    <= pcnt_n;
         q_shadow  <= shadow_n;
         jk_j      <= j_n;
         jk_k      <= k_n;
         jk_preset <= pre_n;
         clear_q   <= clr_n;
         busy      <= busy_n;
         done      <= done_n;
         cmd_ready <= ready_n;
      end
   end

   // Next state; outputs are decoded for the state being entered
   always_comb begin
      state_n  = state;
      op_n     = op_q;
      data_n   = data_q;
      cnt_n    = cnt_q;
      pcnt_n   = pcnt_q;
      shadow_n = q_shadow;
      j_n      = '0;
      k_n      = '0;
      pre_n    = '0;
      clr_n    = '0;
      upd_n    = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      ready_n  = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_n   = cmd_op;
               data_n = cmd_data;
               case (cmd_op)
                  OP_NOP: state_n = FIN;
                  OP_CLEAR, OP_PRESET: begin
                     state_n  = PULSE;
                     pcnt_n   = PC_W'(PULSE_CYC - 1);
                     upd_n    = 1'b1;
                     if (cmd_op == OP_CLEAR) begin
                        clr_n    = '1;
                        shadow_n = '0;
                     end else begin
                        pre_n    = '1;
                        shadow_n = '1;
                     end
                  end
                  OP_LOAD: begin
                     state_n    = STEP;
                     cnt_n      = LEN_W'(1);
                     {j_n, k_n} = jk_calc(cmd_op, q_shadow, cmd_data);
                  end
                  default: begin
                     if (cmd_len == '0) begin
                        state_n = FIN;
                     end else begin
                        state_n    = STEP;
                        cnt_n      = cmd_len;
                        {j_n, k_n} = jk_calc(cmd_op, q_shadow, cmd_data);
                     end
                  end
               endcase
            end
         end
         PULSE: begin
            if (pcnt_q == '0) begin
               state_n = RECOVER;
            end else begin
               pcnt_n = pcnt_q - PC_W'(1);
               clr_n  = (op_q == OP_CLEAR)  ? '1 : '0;
               pre_n  = (op_q == OP_PRESET) ? '1 : '0;
            end
         end
         RECOVER: state_n = FIN;
         STEP: begin
            // Bank has sampled J/K on the negedge inside this step
            shadow_n = jk_apply(q_shadow, jk_j, jk_k);
            upd_n    = 1'b1;
            if (cnt_q == LEN_W'(1)) begin
               state_n = FIN;
            end else begin
               cnt_n      = cnt_q - LEN_W'(1);
               {j_n, k_n} = jk_calc(op_q, shadow_n, data_q);
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      busy_n  = (state_n != IDLE);
      ready_n = (state_n == IDLE);
      done_n  = (state_n == FIN);
   end

`ifdef JK_SEQ_CHECK_EN
   logic chk_pend;

   // Compare bank against shadow one posedge after each shadow update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_pend <= 1'b0;
         err      <= 1'b0;
      end else begin
         chk_pend <= upd_n;
         if (chk_pend && (q_fb != q_shadow)) begin
            err <= 1'b1;
         end
      end
   end
`else
   logic unused_q_fb;
   assign unused_q_fb = ^q_fb;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK flip-flop bank.
module tb_jk_bank_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned LEN_W = 8;

   localparam logic [2:0] NOP = 3'd0, CLEAR = 3'd1, PRESET = 3'd2, LOAD = 3'd3;
   localparam logic [2:0] UP  = 3'd4, DOWN  = 3'd5, SHL    = 3'd6, HOLD = 3'd7;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [LEN_W-1:0] cmd_len;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] jk_j, jk_k, jk_preset, jk_clear, q_shadow;
   logic             busy, done;
`ifdef JK_SEQ_CHECK_EN
   logic             err;
`endif

   logic [WIDTH-1:0] bank_q;
   logic [WIDTH-1:0] fault;
   logic             pc_any;
   int               n_cmp;
   int               n_bad;
   logic [WIDTH-1:0] exp_q;

   jk_bank_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .PULSE_CYC(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .q_fb      (q_fb),
      .jk_j      (jk_j),
      .jk_k      (jk_k),
      .jk_preset (jk_preset),
      .jk_clear  (jk_clear),
      .q_shadow  (q_shadow),
      .busy      (busy),
      .done      (done)
`ifdef JK_SEQ_CHECK_EN
      ,
      .err       (err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural bank: negedge JK flops, async active-high clear/preset
   assign pc_any = |(jk_preset | jk_clear);
   assign q_fb   = bank_q ^ fault;

   always @(negedge clk or posedge pc_any) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (jk_clear[i])                    bank_q[i] <= 1'b0;
         else if (jk_preset[i])              bank_q[i] <= 1'b1;
         else if (!pc_any || !clk) begin
            case ({jk_j[i], jk_k[i]})
               2'b10:   bank_q[i] <= 1'b1;
               2'b01:   bank_q[i] <= 1'b0;
               2'b11:   bank_q[i] <= ~bank_q[i];
               default: bank_q[i] <= bank_q[i];
            endcase
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command for one accept edge; returns in the first cycle after accept
   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      fault     = '0;
      bank_q    = 4'h9;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
      cmd_data  = '0;
      cmd_len   = '0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      check_eq("rst_clear",  32'(jk_clear), 32'hF);
      check_eq("rst_shadow", 32'(q_shadow), 32'h0);
      check_eq("rst_ready",  32'(cmd_ready), 32'h0);
      check_eq("rst_busy",   32'(busy), 32'h0);
      check_eq("rst_jk",     32'({jk_j, jk_k, jk_preset}), 32'h0);
      repeat (2) tick();
      check_eq("rst_bank", 32'(bank_q), 32'h0);
      rst_n = 1'b1;
      #1;
      check_eq("rel_clear", 32'(jk_clear), 32'h0);
      check_eq("rel_ready_pre", 32'(cmd_ready), 32'h0);
      tick();
      check_eq("rel_ready", 32'(cmd_ready), 32'h1);

      // NOP: done the cycle after accept
      issue(NOP, 4'h0, 8'd0);
      check_eq("nop_done", 32'(done), 32'h1);
      check_eq("nop_busy", 32'(busy), 32'h1);
      tick();
      check_eq("nop_idle", 32'({cmd_ready, done, busy}), 32'b100);

      // LOAD 0xA
      issue(LOAD, 4'hA, 8'd0);
      check_eq("ld_j", 32'(jk_j), 32'hA);
      check_eq("ld_k", 32'(jk_k), 32'h5);
      tick();
      check_eq("ld_done",   32'(done), 32'h1);
      check_eq("ld_shadow", 32'(q_shadow), 32'hA);
      check_eq("ld_bank",   32'(bank_q), 32'hA);
      tick();

      // UP x7 from 0xA wraps to 0x1
      issue(UP, 4'h0, 8'd7);
      check_eq("up_t1", 32'(jk_j), 32'h1);
      check_eq("up_k1", 32'(jk_k), 32'h1);
      exp_q = 4'hA;
      for (int s = 1; s <= 7; s++) begin
         tick();
         exp_q = exp_q + 4'h1;
         check_eq("up_shadow", 32'(q_shadow), 32'(exp_q));
         check_eq("up_bank",   32'(bank_q), 32'(exp_q));
         if (s == 1) check_eq("up_t2", 32'(jk_j), 32'h7);
         check_eq("up_done", 32'(done), (s == 7) ? 32'h1 : 32'h0);
      end
      check_eq("up_wrap", 32'(q_shadow), 32'h1);
      tick();
      check_eq("up_done_once", 32'(done), 32'h0);

      // CLEAR: two cycles of clear, one recovery, then done
      issue(CLEAR, 4'h0, 8'd0);
      check_eq("clr_p1",     32'(jk_clear), 32'hF);
      check_eq("clr_shadow", 32'(q_shadow), 32'h0);
      tick();
      check_eq("clr_p2", 32'(jk_clear), 32'hF);
      tick();
      check_eq("clr_rec", 32'(jk_clear), 32'h0);
      check_eq("clr_rec_done", 32'(done), 32'h0);
      tick();
      check_eq("clr_done", 32'(done), 32'h1);
      check_eq("clr_bank", 32'(bank_q), 32'h0);
      tick();

      // DOWN x1 from 0 gives 0xF
      issue(DOWN, 4'h0, 8'd1);
      check_eq("dn_j", 32'(jk_j), 32'hF);
      check_eq("dn_k", 32'(jk_k), 32'hF);
      tick();
      check_eq("dn_done",   32'(done), 32'h1);
      check_eq("dn_shadow", 32'(q_shadow), 32'hF);
      check_eq("dn_bank",   32'(bank_q), 32'hF);
      tick();

      // LOAD 3 then PRESET
      issue(LOAD, 4'h3, 8'd0);
      tick();
      check_eq("ld3_shadow", 32'(q_shadow), 32'h3);
      tick();
      issue(PRESET, 4'h0, 8'd0);
      check_eq("pre_p1",     32'(jk_preset), 32'hF);
      check_eq("pre_shadow", 32'(q_shadow), 32'hF);
      tick();
      check_eq("pre_p2", 32'(jk_preset), 32'hF);
      tick();
      check_eq("pre_rec", 32'(jk_preset), 32'h0);
      check_eq("pre_rec_done", 32'(done), 32'h0);
      tick();
      check_eq("pre_done", 32'(done), 32'h1);
      check_eq("pre_bank", 32'(bank_q), 32'hF);
      tick();
      check_eq("pre_ready", 32'(cmd_ready), 32'h1);

      // CLEAR, then SHL x3 with serial-in 1 while a LOAD 5 waits
      issue(CLEAR, 4'h0, 8'd0);
      repeat (4) tick();
      issue(SHL, 4'h1, 8'd3);
      cmd_valid = 1'b1;
      cmd_op    = LOAD;
      cmd_data  = 4'h5;
      check_eq("shl_j",  32'(jk_j), 32'h1);
      check_eq("shl_k",  32'(jk_k), 32'hE);
      check_eq("shl_rdy", 32'(cmd_ready), 32'h0);
      tick();
      check_eq("shl_s1", 32'(q_shadow), 32'h1);
      tick();
      check_eq("shl_s2", 32'(q_shadow), 32'h3);
      tick();
      check_eq("shl_s3",   32'(q_shadow), 32'h7);
      check_eq("shl_bank", 32'(bank_q), 32'h7);
      check_eq("shl_done", 32'(done), 32'h1);
      check_eq("shl_blk",  32'(cmd_ready), 32'h0);
      tick();
      check_eq("pend_ready",  32'(cmd_ready), 32'h1);
      check_eq("pend_shadow", 32'(q_shadow), 32'h7);
      tick();
      cmd_valid = 1'b0;
      check_eq("pend_j",    32'(jk_j), 32'h5);
      check_eq("pend_busy", 32'(busy), 32'h1);
      tick();
      check_eq("pend_shadow2", 32'(q_shadow), 32'h5);
      check_eq("pend_done",    32'(done), 32'h1);
      tick();

      // HOLD with length 0 finishes at once, no bank change
      issue(HOLD, 4'h0, 8'd0);
      check_eq("h0_done", 32'(done), 32'h1);
      check_eq("h0_jk",   32'({jk_j, jk_k}), 32'h0);
      check_eq("h0_shadow", 32'(q_shadow), 32'h5);
      tick();

      // UP from 0xF wraps to 0
      issue(LOAD, 4'hF, 8'd0);
      repeat (2) tick();
      issue(UP, 4'h0, 8'd1);
      check_eq("upf_j", 32'(jk_j), 32'hF);
      tick();
      check_eq("upf_shadow", 32'(q_shadow), 32'h0);
      check_eq("upf_bank",   32'(bank_q), 32'h0);
      tick();

`ifdef JK_SEQ_CHECK_EN
      check_eq("err_clean", 32'(err), 32'h0);
      issue(LOAD, 4'h6, 8'd0);
      fault = 4'h4;
      tick();
      check_eq("err_not_yet", 32'(err), 32'h0);
      tick();
      check_eq("err_set", 32'(err), 32'h1);
      fault = 4'h0;
      issue(NOP, 4'h0, 8'd0);
      tick();
      check_eq("err_sticky", 32'(err), 32'h1);
`endif

      // Reset mid-operation: bank cleared, no done
      issue(UP, 4'h0, 8'd20);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check_eq("mid_clear",  32'(jk_clear), 32'hF);
      check_eq("mid_shadow", 32'(q_shadow), 32'h0);
      check_eq("mid_busy",   32'({busy, done}), 32'h0);
      check_eq("mid_bank",   32'(bank_q), 32'h0);
`ifdef JK_SEQ_CHECK_EN
      check_eq("mid_err", 32'(err), 32'h0);
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check_eq("mid_ready", 32'(cmd_ready), 32'h1);
      check_eq("mid_done",  32'(done), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
